// File: rtl/half_duplex_line_xfer.sv
// Half-duplex serial engine for one bidirectional pad: drives io_i/io_t,
// samples io_o via 2-flop sync; cmd handshake in, done/rsp_data/mismatch out.
module half_duplex_line_xfer #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic [WIDTH-1:0] rsp_data,
  output logic             mismatch,
  output logic             io_i,
  output logic             io_t,
  input  logic             io_o
);

  localparam int CMAX = (BIT_CYCLES > TURN_CYCLES) ?
                        BIT_CYCLES : TURN_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cyc;
  logic [BW-1:0]     r_bit;
  logic [WIDTH-1:0]  r_sh;
  logic [WIDTH-1:0]  r_rx;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_wr;
  logic              r_s1;
  logic              r_s2;
  logic              r_ready;
  logic              r_done;
  logic              r_io_t;
  logic [WIDTH-1:0]  r_rsp;
  logic              r_mm;

  logic              w_bit_end;
  logic              w_turn_end;
  logic              w_last;
  logic [WIDTH-1:0]  w_rx_next;
  logic [WIDTH-1:0]  w_sh_next;

  assign w_bit_end  = (r_cyc == CW'(BIT_CYCLES - 1));
  assign w_turn_end = (r_cyc == CW'(TURN_CYCLES - 1));
  assign w_last     = (r_bit == BW'(WIDTH - 1));
  assign w_rx_next  = {r_rx[WIDTH-2:0], r_s2};
  assign w_sh_next  = {r_sh[WIDTH-2:0], 1'b0};

  // io_i is the shift register MSB; it is zero outside a write so the
  // pad data input is quiet whenever the line is released.
  assign io_i      = r_sh[WIDTH-1];
  assign io_t      = r_io_t;
  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign rsp_data  = r_rsp;
  assign mismatch  = r_mm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= io_o;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_rx    <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_io_t  <= 1'b1;
      r_rsp   <= '0;
      r_mm    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_wr    <= cmd_write;
            r_wdata <= cmd_data;
            r_sh    <= cmd_write ? cmd_data : '0;
            r_rx    <= '0;
            r_cyc   <= '0;
            r_bit   <= '0;
            r_ready <= 1'b0;
            r_io_t  <= ~cmd_write;
            r_state <= cmd_write ? S_DRIVE : S_TURN;
          end
        end
        S_DRIVE: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            r_rx  <= w_rx_next;
            r_sh  <= w_sh_next;
            r_bit <= r_bit + BW'(1);
            if (w_last) begin
              r_io_t  <= 1'b1;
              r_state <= S_TURN;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_TURN: begin
          if (w_turn_end) begin
            r_cyc <= '0;
            if (r_wr) begin
              r_done  <= 1'b1;
              r_rsp   <= r_rx;
              r_mm    <= (r_rx != r_wdata);
              r_state <= S_DONE;
            end else begin
              r_state <= S_SAMPLE;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_SAMPLE: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            r_rx  <= w_rx_next;
            r_bit <= r_bit + BW'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_rsp   <= w_rx_next;
              r_mm    <= 1'b0;
              r_state <= S_DONE;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_io_t  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_half_duplex_line_xfer.sv
// Self-checking bench for half_duplex_line_xfer (default parameters):
// cycle-accurate pad checks per task plus a done-time scoreboard.
module tb_half_duplex_line_xfer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [W-1:0] cmd_data;
  logic         done;
  logic [W-1:0] rsp_data;
  logic         mismatch;
  logic         io_i;
  logic         io_t;
  logic         io_o;

  logic         frc_en;
  logic         frc_val;
  logic         bench_val;

  typedef struct {
    logic [W-1:0] rsp;
    logic         mm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Pad model: forced value, else the core's own drive, else the far end.
  assign io_o = frc_en ? frc_val : (io_t ? bench_val : io_i);

  half_duplex_line_xfer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_data  (cmd_data),
    .done      (done),
    .rsp_data  (rsp_data),
    .mismatch  (mismatch),
    .io_i      (io_i),
    .io_t      (io_t),
    .io_o      (io_o)
  );

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done rsp=%h", rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_data !== e.rsp) begin
          errors++;
          $display("FAIL sb_rsp got=%h exp=%h", rsp_data, e.rsp);
        end
        checks++;
        if (mismatch !== e.mm) begin
          errors++;
          $display("FAIL sb_mismatch got=%b exp=%b", mismatch, e.mm);
        end
      end
    end
  end

  // Entered at the negedge of the accept cycle (cycle 0); returns at the
  // negedge of cycle 36, which can be the next command's cycle 0.
  task automatic xfer(input bit wr, input logic [W-1:0] d,
                      input logic [W-1:0] rdw, input bit frc,
                      input bit frcv, input bit keep, input bit nwr,
                      input logic [W-1:0] erx, input bit emm);
    exp_t e;
    logic exp_t_v;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_data  = d;
    frc_en    = frc;
    frc_val   = frcv;
    bench_val = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_c0 got=%b exp=1", cmd_ready);
    end
    e.rsp = erx;
    e.mm  = emm;
    sb.push_back(e);
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (keep) cmd_write = nwr;
        else cmd_valid = 1'b0;
      end
      bench_val = (n >= 3 && n <= 34) ? rdw[W-1-(n-3)/4] : 1'b1;
      exp_t_v = (wr && n <= 32) ? 1'b0 : 1'b1;
      checks++;
      if (io_t !== exp_t_v) begin
        errors++;
        $display("FAIL io_t c%0d got=%b exp=%b", n, io_t, exp_t_v);
      end
      if (wr && n <= 32) begin
        checks++;
        if (io_i !== d[W-1-(n-1)/4]) begin
          errors++;
          $display("FAIL io_i c%0d got=%b exp=%b", n, io_i,
                   d[W-1-(n-1)/4]);
        end
      end
      checks++;
      if (done !== (n == 35)) begin
        errors++;
        $display("FAIL done c%0d got=%b exp=%b", n, done, n == 35);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready c%0d got=%b exp=0", n, cmd_ready);
      end
    end
    @(negedge clk);
    frc_en = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL c36 ready=%b done=%b exp 1/0", cmd_ready, done);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++;
    if (io_t !== 1'b1 || io_i !== 1'b0 || done !== 1'b0 ||
        cmd_ready !== 1'b1 || rsp_data !== '0 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset t=%b i=%b d=%b r=%b rsp=%h mm=%b exp 1/0/0/1/00/0",
               io_t, io_i, done, cmd_ready, rsp_data, mismatch);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_loop;
    xfer(1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    idle(3);
  endtask

  task automatic test_read;
    xfer(1'b0, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    idle(2);
  endtask

  task automatic test_contention;
    xfer(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);
  endtask

  task automatic test_back_to_back;
    xfer(1'b1, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0);
    xfer(1'b0, 8'h81, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    idle(2);
  endtask

  task automatic test_reset_mid;
    int ndone;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'hA5;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ready_c0 got=%b exp=1", cmd_ready);
    end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checks++;
    if (io_t !== 1'b0 || io_i !== 1'b1) begin
      errors++;
      $display("FAIL rmid_c10 t=%b i=%b exp 0/1", io_t, io_i);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (io_t !== 1'b1 || io_i !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_after t=%b i=%b r=%b exp 1/0/1",
               io_t, io_i, cmd_ready);
    end
    rst   = 1'b0;
    ndone = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rmid_no_done got=%0d exp=0", ndone);
    end
    xfer(1'b0, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0);
    idle(2);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_data  = '0;
    frc_en    = 1'b0;
    frc_val   = 1'b0;
    bench_val = 1'b1;
    @(negedge clk);
    test_reset;
    test_write_loop;
    test_read;
    test_contention;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/half_duplex_line_xfer.md
# half_duplex_line_xfer

Serial engine that moves WIDTH-bit words over one bidirectional pad, one direction at a time. It sits directly upstream of the tri-state pad buffer. It drives the buffer's I input (io_i) and its T input (io_t, 1 = high-Z), and it samples the buffer's O output (io_o). Fabric logic issues read or write commands through a valid/ready handshake. Each command returns the sampled line word on a one-cycle done pulse.

## Interface
Parameters:
- WIDTH, 8: bits per transfer, sent and received MSB first.
- BIT_CYCLES, 4: clock cycles per bit. Must be ≥ 4.
- TURN_CYCLES, 2: bus-release (turnaround) cycles. Must be ≥ 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write (drive the line), 0 = read (release the line and sample).
- cmd_data  in  WIDTH  write word; ignored for reads.
- done  out  1  one-cycle pulse at the end of every command.
- rsp_data  out  WIDTH  word sampled from the line; valid while done = 1 and held until the next done.
- mismatch  out  1  valid with done. Set to 1 on a write whose readback differs from cmd_data. Always 0 for reads.
- io_i  out  1  pad drive value.
- io_t  out  1  pad tri-state control; 1 = released.
- io_o  in  1  pad value, asynchronous to clk.

## Operation
- io_o passes through a 2-flop synchronizer (io_s). All sampling uses io_s.
- States:
  - IDLE: cmd_ready = 1; io_t = 1. On accept, latch cmd_write and cmd_data, clear the bit and cycle counters, then go to DRIVE (write) or TURN (read).
  - DRIVE: io_t = 0; io_i = the current MSB of the shift register.
  - TURN: io_t = 1.
  - SAMPLE: io_t = 1.
  - DONE: io_t = 1; done = 1; cmd_ready = 0. Always returns to IDLE.
- Bit timing:
  - A cycle counter runs 0..BIT_CYCLES-1 per bit.
  - The data shift register advances when the counter wraps.
  - The sample is taken on the edge ending the cycle where the counter = BIT_CYCLES-1: io_s shifts into the receive register LSB.
  - This sampling is active in both DRIVE (loopback) and SAMPLE.
- Transitions:
  - Write: DRIVE → TURN after WIDTH bits; TURN → DONE after TURN_CYCLES.
  - Read: TURN → SAMPLE after TURN_CYCLES; SAMPLE → DONE after WIDTH bits.
  - The TURN state is used in both directions: after a write it releases the bus before the next command; before a read it gives the far end time to start driving.
- Commands arriving when cmd_ready = 0 are not accepted. cmd_valid may stay high; the command is accepted on the first IDLE cycle.
- Reset (including mid-transfer):
  - State → IDLE; io_t = 1; io_i = 0; done = 0; mismatch = 0; rsp_data = 0; counters and shift registers = 0; synchronizer = 1.
  - The aborted command produces no done pulse.

## Timing
- Cycle 0 is the cycle in which accept happens; cycle n follows the n-th edge after it.
- Write: io_t = 0 in cycles 1..WIDTH·BIT_CYCLES. Bit k (k = 0 is the MSB) is driven in cycles k·BIT_CYCLES+1 .. (k+1)·BIT_CYCLES. io_t = 1 from cycle WIDTH·BIT_CYCLES+1.
- Read: TURN occupies cycles 1..TURN_CYCLES. Bit k is expected on the line in cycles TURN_CYCLES + k·BIT_CYCLES + 1 .. TURN_CYCLES + (k+1)·BIT_CYCLES.
- Both directions: done in cycle WIDTH·BIT_CYCLES + TURN_CYCLES + 1; cmd_ready = 1 one cycle later. Minimum command spacing is WIDTH·BIT_CYCLES + TURN_CYCLES + 2 cycles.
- Sampling latency: the synchronizer delays the line by 2 cycles, so a sample reflects the pad at counter = BIT_CYCLES-3. This is why BIT_CYCLES ≥ 4.
- io_t and io_i are registered outputs: no combinational path from any input to them.

## Test plan
All scenarios use the default parameters.
- Write 0xA5 with io_o looped back to io_i when io_t = 0:
  - io_t = 0 in cycles 1..32.
  - io_i sequence is 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - io_t = 1 in cycles 33..34.
  - done in cycle 35 with rsp_data = 0xA5 and mismatch = 0.
- Read with the bench driving 0x3C MSB-first, one bit per 4 cycles starting in cycle 3:
  - io_t = 1 throughout.
  - done in cycle 35 with rsp_data = 0x3C and mismatch = 0.
- Contention: write 0xFF while the bench forces io_o = 0 → done in cycle 35 with rsp_data = 0x00 and mismatch = 1.
- Back-to-back: cmd_valid held high with a write 0x81 followed by a read:
  - The second accept happens in cycle 36 (its own cycle 0).
  - cmd_ready = 0 in cycles 1..35.
  - No second accept occurs while busy.
- Reset asserted in cycle 10 of a write:
  - On the next edge io_t = 1, io_i = 0 and cmd_ready = 1.
  - No done pulse follows.
  - A subsequent read then completes normally.
